// File: rtl/vec_max_reduce.sv
// Streaming 8-lane fp16 max reduction: folds a vector of 8-element beats into one
// scalar maximum (sign-magnitude total order) plus its beat count, with valid/ready flow.
module vec_max_reduce #(
  parameter int DATAWIDTH = 16,
  parameter int EXPONENT  = 5,
  parameter int MANTISSA  = 10,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [DATAWIDTH-1:0] inp0,
  input  logic [DATAWIDTH-1:0] inp1,
  input  logic [DATAWIDTH-1:0] inp2,
  input  logic [DATAWIDTH-1:0] inp3,
  input  logic [DATAWIDTH-1:0] inp4,
  input  logic [DATAWIDTH-1:0] inp5,
  input  logic [DATAWIDTH-1:0] inp6,
  input  logic [DATAWIDTH-1:0] inp7,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] max_out,
  output logic [CNTWIDTH-1:0]  beat_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int MAG_W = EXPONENT + MANTISSA;
  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  // Sign-magnitude max; on equal bit patterns the first operand is kept.
  function automatic logic [DATAWIDTH-1:0] fmax(input logic [DATAWIDTH-1:0] a,
                                                input logic [DATAWIDTH-1:0] b);
    logic b_wins;
    if (a[DATAWIDTH-1] != b[DATAWIDTH-1])
      b_wins = !b[DATAWIDTH-1];
    else if (!a[DATAWIDTH-1])
      b_wins = b[MAG_W-1:0] > a[MAG_W-1:0];
    else
      b_wins = b[MAG_W-1:0] < a[MAG_W-1:0];
    return b_wins ? b : a;
  endfunction

  logic                 adv;
  logic [DATAWIDTH-1:0] lvl1 [4];
  logic [DATAWIDTH-1:0] lvl2 [2];
  logic [DATAWIDTH-1:0] tree_max;

  logic                 a_valid;
  logic                 a_last;
  logic [DATAWIDTH-1:0] a_max;

  logic                 acc_open;
  logic [CNTWIDTH-1:0]  acc_cnt;
  logic [DATAWIDTH-1:0] acc_max;

  logic [DATAWIDTH-1:0] fold_max;
  logic [CNTWIDTH-1:0]  fold_cnt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign lvl1[0]  = fmax(inp0, inp1);
  assign lvl1[1]  = fmax(inp2, inp3);
  assign lvl1[2]  = fmax(inp4, inp5);
  assign lvl1[3]  = fmax(inp6, inp7);
  assign lvl2[0]  = fmax(lvl1[0], lvl1[1]);
  assign lvl2[1]  = fmax(lvl1[2], lvl1[3]);
  assign tree_max = fmax(lvl2[0], lvl2[1]);

  // A closed accumulator restarts from the incoming beat rather than merging.
  always_comb begin
    fold_max = a_max;
    fold_cnt = CNTWIDTH'(1);
    if (acc_open) begin
      fold_max = fmax(acc_max, a_max);
      fold_cnt = (acc_cnt == CNT_MAX) ? CNT_MAX : acc_cnt + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_valid    <= 1'b0;
      a_last     <= 1'b0;
      a_max      <= '0;
      acc_open   <= 1'b0;
      acc_cnt    <= '0;
      acc_max    <= '0;
      out_valid  <= 1'b0;
      max_out    <= '0;
      beat_count <= '0;
    end else if (adv) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_max  <= tree_max;
        a_last <= in_last;
      end
      // A fresh load keeps out_valid high even while the old result is taken.
      out_valid <= a_valid && a_last;
      if (a_valid) begin
        if (a_last) begin
          max_out    <= fold_max;
          beat_count <= fold_cnt;
          acc_open   <= 1'b0;
        end else begin
          acc_max  <= fold_max;
          acc_cnt  <= fold_cnt;
          acc_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_max_reduce.sv
// Randomized and directed bench for vec_max_reduce against an ordering-key
// reference model; results are scoreboarded in order via a queue.
module tb_vec_max_reduce;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_last;
  logic [15:0] lane_drv [8];
  logic        in_ready;
  logic [15:0] max_out;
  logic [7:0]  beat_count;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int ready_mode = 1;
  logic no_bubble = 1'b0;

  logic [15:0] vec_buf [300][8];
  int exp_max_q [$];
  int exp_cnt_q [$];

  vec_max_reduce dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_last(in_last),
    .inp0(lane_drv[0]), .inp1(lane_drv[1]), .inp2(lane_drv[2]), .inp3(lane_drv[3]),
    .inp4(lane_drv[4]), .inp5(lane_drv[5]), .inp6(lane_drv[6]), .inp7(lane_drv[7]),
    .in_ready(in_ready), .max_out(max_out), .beat_count(beat_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Map each fp16 pattern onto an integer whose natural order is the required order.
  function automatic int orderKey(input logic [15:0] x);
    return x[15] ? 32767 - int'(x[14:0]) : 32768 + int'(x[14:0]);
  endfunction

  function automatic logic [15:0] refMax(input int n);
    logic [15:0] best = vec_buf[0][0];
    for (int b = 0; b < n; b++)
      for (int l = 0; l < 8; l++)
        if (orderKey(vec_buf[b][l]) > orderKey(best)) best = vec_buf[b][l];
    return best;
  endfunction

  function automatic logic [15:0] randElem();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0: v = 16'($urandom);
      1: case ($urandom_range(0, 5))
           0: v = 16'h0000;
           1: v = 16'h8000;
           2: v = 16'h7C00;
           3: v = 16'hFC00;
           4: v = 16'h3C00;
           default: v = 16'hBC00;
         endcase
      default: v = {1'($urandom), 5'($urandom_range(12, 17)), 10'($urandom)};
    endcase
    if (v[14:10] == 5'h1F) v[9:0] = '0;
    return v;
  endfunction

  task automatic stepCycle();
    @(negedge clk);
    #2;
  endtask

  task automatic setBeat(input int b, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                         input logic [15:0] e5, input logic [15:0] e6, input logic [15:0] e7);
    vec_buf[b][0] = e0; vec_buf[b][1] = e1; vec_buf[b][2] = e2; vec_buf[b][3] = e3;
    vec_buf[b][4] = e4; vec_buf[b][5] = e5; vec_buf[b][6] = e6; vec_buf[b][7] = e7;
  endtask

  task automatic fillBeat(input int b, input logic [15:0] v);
    for (int l = 0; l < 8; l++) vec_buf[b][l] = v;
  endtask

  task automatic randBeats(input int n);
    for (int b = 0; b < n; b++)
      for (int l = 0; l < 8; l++) vec_buf[b][l] = randElem();
  endtask

  task automatic sendBeat(input int b, input logic last);
    int guard = 0;
    for (int l = 0; l < 8; l++) lane_drv[l] = vec_buf[b][l];
    in_valid = 1'b1;
    in_last  = last;
    if (no_bubble) checkOutput("no_bubble", 32'(in_ready), 1);
    while (!in_ready && guard < 3000) begin
      stepCycle();
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 32'(in_ready), 1);
    stepCycle();
  endtask

  // Negative expectation arguments mean "derive from the reference model".
  task automatic applyStimulus(input int n, input int exp_max, input int exp_cnt);
    exp_max_q.push_back(exp_max < 0 ? int'(refMax(n)) : exp_max);
    exp_cnt_q.push_back(exp_cnt < 0 ? (n > 255 ? 255 : n) : exp_cnt);
    for (int b = 0; b < n; b++) sendBeat(b, b == n - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_max_q.size() != 0 || out_valid) && guard < 5000) begin
      stepCycle();
      guard++;
    end
    checkOutput("drain", 32'(exp_max_q.size()), 0);
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (resetn && out_valid && out_ready) begin
      if (exp_max_q.size() == 0) begin
        checkOutput("unexpected_result", 32'(out_valid), 0);
      end else begin
        checkOutput("max_out", 32'(max_out), 32'(exp_max_q.pop_front()));
        checkOutput("beat_count", 32'(beat_count), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int l = 0; l < 8; l++) lane_drv[l] = '0;
    #3;
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_max_out", 32'(max_out), 0);
    checkOutput("reset_beat_count", 32'(beat_count), 0);
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    stepCycle();
    stepCycle();
    resetn = 1'b1;
    stepCycle();

    setBeat(0, 16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h3400);
    applyStimulus(1, 'h4000, 1);
    checkOutput("latency_early", 32'(out_valid), 0);
    stepCycle();
    checkOutput("latency_valid", 32'(out_valid), 1);
    checkOutput("latency_max", 32'(max_out), 32'h4000);

    fillBeat(0, 16'hBC00);
    fillBeat(1, 16'hC000);
    fillBeat(2, 16'h3C00);
    vec_buf[2][5] = 16'h7C00;
    applyStimulus(3, 'h7C00, 3);

    setBeat(0, 16'h8000, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00);
    applyStimulus(1, 'h8000, 1);
    setBeat(0, 16'h8000, 16'h0000, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00);
    applyStimulus(1, 'h0000, 1);
    waitDrain();

    ready_mode = 0;
    stepCycle();
    setBeat(0, 16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h3400);
    applyStimulus(1, 'h4000, 1);
    stepCycle();
    stepCycle();
    checkOutput("bp_out_valid", 32'(out_valid), 1);
    fillBeat(0, 16'h3800);
    vec_buf[0][3] = 16'h4400;
    fillBeat(1, 16'hBC00);
    for (int l = 0; l < 8; l++) lane_drv[l] = vec_buf[0][l];
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_in_ready", 32'(in_ready), 0);
      checkOutput("bp_max_hold", 32'(max_out), 32'h4000);
      checkOutput("bp_cnt_hold", 32'(beat_count), 1);
      stepCycle();
    end
    ready_mode = 1;
    applyStimulus(2, 'h4400, 2);
    waitDrain();

    no_bubble = 1'b1;
    randBeats(1);
    applyStimulus(1, -1, 1);
    randBeats(2);
    applyStimulus(2, -1, 2);
    randBeats(4);
    applyStimulus(4, -1, 4);
    no_bubble = 1'b0;
    waitDrain();

    randBeats(4);
    sendBeat(0, 1'b0);
    sendBeat(1, 1'b0);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 0);
    checkOutput("midreset_max_out", 32'(max_out), 0);
    checkOutput("midreset_beat_count", 32'(beat_count), 0);
    checkOutput("midreset_in_ready", 32'(in_ready), 1);
    stepCycle();
    resetn = 1'b1;
    stepCycle();
    fillBeat(0, 16'h3C00);
    applyStimulus(1, 'h3C00, 1);
    waitDrain();

    ready_mode = 2;
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 6);
      randBeats(n);
      applyStimulus(n, -1, -1);
      if ($urandom_range(0, 2) == 0) stepCycle();
    end
    randBeats(255);
    applyStimulus(255, -1, 255);
    randBeats(260);
    applyStimulus(260, -1, 255);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
